colour_conversion_controller: RTL and testbench

FSM that sequences colour_conversion_datapath to convert one YUV frame to RGB. For each pixel pair (one 16-bit word per plane) it:
- reads the Y, U and V words from a single shared memory port and pulses the matching datapath register enables;
- latches the even pixel's RGB into Temp;
- writes the pair's 48-bit RGB result back as three 16-bit words.

It provides a start/done handshake to the top level.

---
 rtl/colour_conversion_controller.sv | 236 +++++++++++++++++++++++
 tb/tb_colour_conversion_controller.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/colour_conversion_controller.sv
// -----------------------------------------------------------------------------
// colour_conversion_controller
//
// Purpose:
//   Sequencer for colour_conversion_datapath. It converts one YUV frame to RGB,
//   one pixel pair at a time. A pixel pair is one 16-bit word per plane.
//   For every pair the controller:
//     - reads the Y, U and V words over a single shared memory port, and loads
//       the matching datapath registers one cycle later, when the read data
//       is valid;
//     - latches the even pixel's RGB into the datapath Temp register;
//     - writes the pair's 48-bit RGB result back as three 16-bit words.
//   Writes can be stalled by the memory. Reads are always accepted.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   start          begin a frame (only looked at in IDLE)
//   done           one-cycle pulse when the frame completes
//   busy           high whenever the FSM is not in IDLE
//   R_addr         datapath pixel-word counter
//   end_of_pixel   datapath flag: R_addr == PIXEL_WORDS
//   mem_stall      memory cannot accept a write this cycle
//   mem_rd         read request (read data valid one cycle later)
//   mem_wr         write request (write data comes from the datapath)
//   mem_addr       read or write address
//   dp_rst         datapath reset (rst, or the per-frame clear pulse)
//   Yen_/Uen_/Ven_even/odd  datapath input register loads
//   Smux1          0 = even pixel to the conversion unit, 1 = odd pixel
//   Smux2          output word select: 0/1/2 = word0/1/2, 3 = idle
//   Temp_en        latch the even pixel's RGB
//   Cen            advance the datapath pixel counter
// -----------------------------------------------------------------------------
module colour_conversion_controller #(
    parameter int PIXEL_WORDS = 38400,
    parameter int U_BASE      = 38400,
    parameter int V_BASE      = 76800,
    parameter int W_BASE      = 115200,
    parameter int AW          = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          done,
    output logic          busy,
    input  logic [AW-1:0] R_addr,
    input  logic          end_of_pixel,
    input  logic          mem_stall,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic          dp_rst,
    output logic          Yen_even,
    output logic          Yen_odd,
    output logic          Uen_even,
    output logic          Uen_odd,
    output logic          Ven_even,
    output logic          Ven_odd,
    output logic          Smux1,
    output logic [1:0]    Smux2,
    output logic          Temp_en,
    output logic          Cen
);

    // Plane bases and the final write-counter value, all in address width.
    localparam logic [AW-1:0] C_U_BASE    = AW'(U_BASE);
    localparam logic [AW-1:0] C_V_BASE    = AW'(V_BASE);
    localparam logic [AW-1:0] C_W_BASE    = AW'(W_BASE);
    localparam logic [AW-1:0] C_WCNT_LAST = AW'(3 * PIXEL_WORDS);
    localparam logic [AW-1:0] C_ONE       = AW'(1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_CLR  = 4'd1,
        S_RY   = 4'd2,
        S_RU   = 4'd3,
        S_RV   = 4'd4,
        S_LV   = 4'd5,
        S_CE   = 4'd6,
        S_W0   = 4'd7,
        S_W1   = 4'd8,
        S_W2   = 4'd9,
        S_CHK  = 4'd10,
        S_DONE = 4'd11
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_wcnt;
    logic [AW-1:0] w_wcnt_next;
    logic          w_wr_slot;   // state is one of the three write states
    logic          w_cen_slot;  // state is the last write of the pair
    logic          w_clr;       // per-frame datapath clear

    // State and write-counter registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_next_state;
            r_wcnt  <= w_wcnt_next;
        end
    end

    // Next-state and next write-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_wcnt_next  = r_wcnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_CLR;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_CLR: begin
                w_wcnt_next  = '0;
                w_next_state = S_RY;
            end
            S_RY:  w_next_state = S_RU;
            S_RU:  w_next_state = S_RV;
            S_RV:  w_next_state = S_LV;
            S_LV:  w_next_state = S_CE;
            S_CE:  w_next_state = S_W0;
            S_W0, S_W1, S_W2: begin
                // A stalled write holds the state and the address.
                if (mem_stall) begin
                    w_next_state = r_state;
                end else begin
                    // The counter stops at its final value instead of
                    // wrapping, so a stray extra write cannot alias the
                    // start of the output area.
                    if (r_wcnt != C_WCNT_LAST) begin
                        w_wcnt_next = r_wcnt + C_ONE;
                    end else begin
                        w_wcnt_next = r_wcnt;
                    end
                    if (r_state == S_W0) begin
                        w_next_state = S_W1;
                    end else if (r_state == S_W1) begin
                        w_next_state = S_W2;
                    end else begin
                        w_next_state = S_CHK;
                    end
                end
            end
            S_CHK: begin
                // end_of_pixel already reflects the Cen issued in W2.
                if (end_of_pixel) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RY;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Moore output decode from the state register.
    always_comb begin
        mem_rd     = 1'b0;
        mem_addr   = '0;
        Yen_even   = 1'b0;
        Yen_odd    = 1'b0;
        Uen_even   = 1'b0;
        Uen_odd    = 1'b0;
        Ven_even   = 1'b0;
        Ven_odd    = 1'b0;
        Smux1      = 1'b0;
        Smux2      = 2'd3;
        Temp_en    = 1'b0;
        done       = 1'b0;
        w_wr_slot  = 1'b0;
        w_cen_slot = 1'b0;
        w_clr      = 1'b0;
        case (r_state)
            S_CLR: w_clr = 1'b1;
            S_RY: begin
                mem_rd   = 1'b1;
                mem_addr = R_addr;
            end
            S_RU: begin
                // Y data from the RY read is valid this cycle.
                mem_rd   = 1'b1;
                mem_addr = C_U_BASE + R_addr;
                Yen_even = 1'b1;
                Yen_odd  = 1'b1;
            end
            S_RV: begin
                mem_rd   = 1'b1;
                mem_addr = C_V_BASE + R_addr;
                Uen_even = 1'b1;
                Uen_odd  = 1'b1;
            end
            S_LV: begin
                Ven_even = 1'b1;
                Ven_odd  = 1'b1;
            end
            S_CE: begin
                Smux1   = 1'b0;
                Temp_en = 1'b1;
            end
            S_W0: begin
                Smux1     = 1'b1;
                Smux2     = 2'd0;
                mem_addr  = C_W_BASE + r_wcnt;
                w_wr_slot = 1'b1;
            end
            S_W1: begin
                Smux1     = 1'b1;
                Smux2     = 2'd1;
                mem_addr  = C_W_BASE + r_wcnt;
                w_wr_slot = 1'b1;
            end
            S_W2: begin
                Smux1      = 1'b1;
                Smux2      = 2'd2;
                mem_addr   = C_W_BASE + r_wcnt;
                w_wr_slot  = 1'b1;
                w_cen_slot = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // A stall suppresses only the write strobe and the pair advance.
    assign mem_wr = w_wr_slot & ~mem_stall;
    assign Cen    = w_cen_slot & ~mem_stall;
    assign dp_rst = rst | w_clr;
    assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_colour_conversion_controller.sv
module tb_colour_conversion_controller;

    localparam int PW = 4;
    localparam int AW = 20;
    localparam int UB = 38400;
    localparam int VB = 76800;
    localparam int WB = 115200;
    localparam int NW = 3 * PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mem_stall = 1'b0;
    logic          done, busy, mem_rd, mem_wr, dp_rst;
    logic [AW-1:0] R_addr;
    logic          end_of_pixel;
    logic [AW-1:0] mem_addr;
    logic          Yen_even, Yen_odd, Uen_even, Uen_odd, Ven_even, Ven_odd;
    logic          Smux1, Temp_en, Cen;
    logic [1:0]    Smux2;

    colour_conversion_controller #(.PIXEL_WORDS(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
        .R_addr(R_addr), .end_of_pixel(end_of_pixel), .mem_stall(mem_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .dp_rst(dp_rst),
        .Yen_even(Yen_even), .Yen_odd(Yen_odd), .Uen_even(Uen_even),
        .Uen_odd(Uen_odd), .Ven_even(Ven_even), .Ven_odd(Ven_odd),
        .Smux1(Smux1), .Smux2(Smux2), .Temp_en(Temp_en), .Cen(Cen)
    );

    always #5 clk = ~clk;

    // ---------------- memory and simple datapath around the controller -----
    logic [15:0] ymem [PW];
    logic [15:0] umem [PW];
    logic [15:0] vmem [PW];
    logic [15:0] R_data;
    logic [7:0]  ye, yo, ue, uo, ve, vo;
    logic [23:0] temp_r, comb;
    logic [15:0] W_data;

    // Toy conversion unit: 8-bit Y/U/V in, 24-bit RGB out.
    function automatic logic [23:0] conv(input logic [7:0] y, input logic [7:0] u,
                                         input logic [7:0] v);
        return {y ^ u, 8'(y + v), 8'(y - u)};
    endfunction

    function automatic logic [15:0] mem_read(input logic [AW-1:0] a);
        int ai;
        ai = int'(a);
        if (ai < PW) return ymem[ai];
        else if (ai >= UB && ai < UB + PW) return umem[ai - UB];
        else if (ai >= VB && ai < VB + PW) return vmem[ai - VB];
        else return 16'hDEAD;
    endfunction

    always @(posedge clk) begin
        if (mem_rd) R_data <= mem_read(mem_addr);
        if (dp_rst) R_addr <= '0;
        else if (Cen) R_addr <= R_addr + 20'd1;
        if (Yen_even) ye <= R_data[7:0];
        if (Yen_odd)  yo <= R_data[15:8];
        if (Uen_even) ue <= R_data[7:0];
        if (Uen_odd)  uo <= R_data[15:8];
        if (Ven_even) ve <= R_data[7:0];
        if (Ven_odd)  vo <= R_data[15:8];
        if (Temp_en)  temp_r <= comb;
    end

    assign comb = Smux1 ? conv(yo, uo, vo) : conv(ye, ue, ve);
    assign end_of_pixel = (R_addr == 20'(PW));

    always_comb begin
        case (Smux2)
            2'd0:    W_data = temp_r[23:8];
            2'd1:    W_data = {temp_r[7:0], comb[23:16]};
            2'd2:    W_data = comb[15:0];
            default: W_data = 16'h0000;
        endcase
    end

    // ---------------- scoreboard ------------------------------------------
    typedef struct { logic [AW-1:0] addr; logic [15:0] data; } wr_t;
    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            n_rd = 0;
    int            n_wr = 0;
    int            stall_plan [NW];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the frame's reads and writes straight from the plane contents.
    task automatic push_frame();
        logic [47:0] rgb;
        for (int p = 0; p < PW; p++) begin
            exp_rd.push_back(AW'(p));
            exp_rd.push_back(AW'(UB + p));
            exp_rd.push_back(AW'(VB + p));
            rgb = {conv(ymem[p][7:0], umem[p][7:0], vmem[p][7:0]),
                   conv(ymem[p][15:8], umem[p][15:8], vmem[p][15:8])};
            for (int k = 0; k < 3; k++)
                exp_wr.push_back('{addr: AW'(WB + 3 * p + k), data: rgb[47 - 16 * k -: 16]});
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < PW; i++) begin
            ymem[i] = 16'($urandom);
            umem[i] = 16'($urandom);
            vmem[i] = 16'($urandom);
        end
    endtask

    // Monitor: pops and compares whenever the DUT presents a read or a write.
    logic          prev_rd = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_rd = 1'b0;
        end else begin
            if (mem_rd && mem_wr) check("rd_wr_exclusive", 64'd1, 64'd0);
            if (Smux2 != 2'd3) check("wr_gating", {63'd0, mem_wr}, {63'd0, !mem_stall});
            if (mem_rd) begin
                n_rd++;
                if (exp_rd.size() == 0) check("unexpected_rd", 64'(mem_addr), 64'hFFFFF);
                else check("rd_addr", 64'(mem_addr), 64'(exp_rd.pop_front()));
            end
            if (mem_wr) begin
                wr_t e;
                n_wr++;
                if (exp_wr.size() == 0) check("unexpected_wr", 64'(mem_addr), 64'hFFFFF);
                else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e.addr));
                    check("wr_data", 64'(W_data), 64'(e.data));
                end
            end
            if (Yen_even || Yen_odd) begin
                check("y_en_after_rd", {63'd0, prev_rd}, 64'd1);
                check("y_en_plane", {63'd0, int'(prev_addr) < PW}, 64'd1);
            end
            if (Uen_even || Uen_odd) begin
                check("u_en_after_rd", {63'd0, prev_rd}, 64'd1);
                check("u_en_plane", {63'd0, int'(prev_addr) >= UB && int'(prev_addr) < UB + PW}, 64'd1);
            end
            if (Ven_even || Ven_odd) begin
                check("v_en_after_rd", {63'd0, prev_rd}, 64'd1);
                check("v_en_plane", {63'd0, int'(prev_addr) >= VB && int'(prev_addr) < VB + PW}, 64'd1);
            end
            prev_rd   = mem_rd;
            prev_addr = mem_addr;
        end
    end

    // Stall driver: holds mem_stall for stall_plan[k] cycles at write k.
    initial begin
        int rem;
        int idx;
        bit in_w;
        rem = 0;
        in_w = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && Smux2 != 2'd3) begin
                if (!in_w) begin
                    in_w = 1'b1;
                    idx = int'(mem_addr) - WB;
                    rem = (idx >= 0 && idx < NW) ? stall_plan[idx] : 0;
                end
                if (rem > 0) begin
                    mem_stall = 1'b1;
                    rem--;
                end else begin
                    mem_stall = 1'b0;
                    in_w = 1'b0;
                end
            end else begin
                mem_stall = 1'b0;
                in_w = 1'b0;
            end
        end
    end

    function automatic int plan_sum();
        int s;
        s = 0;
        for (int i = 0; i < NW; i++) s += stall_plan[i];
        return s;
    endfunction

    // One frame from a single start pulse; len = cycle of done after start.
    task automatic run_frame(input int exp_len);
        int len;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        len = 1;
        while (!done && len < 400) begin
            @(posedge clk); #1;
            len++;
            if (len == 2) check("first_rd_cycle", {63'd0, mem_rd}, 64'd1);
        end
        check("done_cycle", 64'(len), 64'(exp_len));
        @(posedge clk); #1;
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("idle_after_done", {63'd0, busy}, 64'd0);
        check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        check("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    endtask

    initial begin
        int n;
        int l1;
        for (int i = 0; i < NW; i++) stall_plan[i] = 0;

        // Reset behaviour.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dp_rst", {63'd0, dp_rst}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_smux2", 64'(Smux2), 64'd3);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("idle_busy", {63'd0, busy}, 64'd0);
            check("idle_done", {63'd0, done}, 64'd0);
            check("idle_smux2", 64'(Smux2), 64'd3);
            check("idle_dp_rst", {63'd0, dp_rst}, 64'd0);
            check("idle_strobes", {63'd0, |{Yen_even, Yen_odd, Uen_even, Uen_odd, Ven_even,
                                          Ven_odd, mem_rd, mem_wr, Temp_en, Cen, Smux1}}, 64'd0);
        end

        // Plain frame, no stalls.
        fill_mem();
        push_frame();
        n_rd = 0;
        n_wr = 0;
        run_frame(38);
        check("total_reads", 64'(n_rd), 64'(NW));
        check("total_writes", 64'(n_wr), 64'(NW));

        // Three stall cycles on the first W1.
        stall_plan[1] = 3;
        fill_mem();
        push_frame();
        run_frame(41);
        stall_plan[1] = 0;

        // Random contents and random stall patterns.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NW; i++)
                stall_plan[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            fill_mem();
            push_frame();
            run_frame(38 + plan_sum());
        end
        for (int i = 0; i < NW; i++) stall_plan[i] = 0;

        // Reset during pair 2, W1.
        fill_mem();
        push_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!(Smux2 == 2'd1 && int'(mem_addr) == WB + 7) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_pair2_w1", {63'd0, n < 200}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_smux2", 64'(Smux2), 64'd3);
        check("abort_dp_rst", {63'd0, dp_rst}, 64'd1);
        check("abort_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        exp_wr.delete();
        exp_rd.delete();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("abort_no_done", {63'd0, done | busy}, 64'd0);
        end
        fill_mem();
        push_frame();
        run_frame(38);

        // start held high: back-to-back frames with one IDLE cycle between.
        fill_mem();
        push_frame();
        push_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        n = 1;
        while (!done && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        l1 = n;
        check("b2b_first_done", 64'(l1), 64'd38);
        @(posedge clk); #1;
        n++;
        check("b2b_idle_gap", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        n++;
        check("b2b_restart", {63'd0, busy}, 64'd1);
        while (!done && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("b2b_second_done", 64'(n - l1), 64'd39);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_stopped", {63'd0, busy}, 64'd0);
        check("b2b_wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        check("b2b_rd_queue_empty", 64'(exp_rd.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
